// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron layer sequencer.
// Optional feature macro used by this slice: NEURON_SCHED_RELU_EN.
package nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_FRAC_BITS = 8;

  // Arithmetic right shift (floor) then clamp to a dw-bit signed range.
  // Works on a 64-bit carrier, so the accumulator must be at most 64 bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] v,
                                                   input int sh, input int dw);
    logic signed [63:0] s, hi, lo;
    s  = v >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/neuron_post.sv
// Per-neuron post-processing: fold in the last product and bias, quantize,
// saturate and optionally clamp negatives (NEURON_SCHED_RELU_EN).
module neuron_post
  import nn_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic signed [ACC_W-1:0]    acc,
  input  logic signed [2*DATA_W-1:0] prod,
  input  logic signed [DATA_W-1:0]   bias,
  output logic signed [DATA_W-1:0]   q
);

  logic signed [ACC_W-1:0]  sum;
  logic signed [DATA_W-1:0] qs;

  // Sum wraps at accumulator width; saturation happens only after the shift.
  always_comb begin
    sum = acc + ACC_W'(prod) + ACC_W'(bias);
    qs  = DATA_W'(sat_shift(64'(sum), FRAC_BITS, DATA_W));
`ifdef NEURON_SCHED_RELU_EN
    q   = qs[DATA_W-1] ? '0 : qs;
`else
    q   = qs;
`endif
  end

endmodule

// File: rtl/neuron_layer_sched.sv
// Fully connected layer sequencer: one shared MAC walks every neuron,
// then bias/quantize/saturate (ReLU when NEURON_SCHED_RELU_EN is defined)
// and writes one result per neuron into the activation buffer.
module neuron_layer_sched
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int FRAC_BITS   = DEF_FRAC_BITS,
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int WW = (NUM_NEURONS * NUM_INPUTS > 1) ? $clog2(NUM_NEURONS * NUM_INPUTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [IW-1:0]            in_addr,
  output logic [WW-1:0]            w_addr,
  output logic [NW-1:0]            bias_addr,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic signed [DATA_W-1:0] bias_data,
  output logic                     out_we,
  output logic [NW-1:0]            out_addr,
  output logic signed [DATA_W-1:0] out_data
);

  state_t                    state;
  logic [IW-1:0]             i;
  logic [NW-1:0]             n;
  logic signed [ACC_W-1:0]   acc;
  logic                      rd_vld;   // read data on the bus belongs to an issued address
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]  post_q;

  // Addresses come straight from the counters, so they are valid the cycle
  // after the counters update. Bias and output address track the neuron.
  assign in_addr   = i;
  assign w_addr    = WW'(n) * WW'(NUM_INPUTS) + WW'(i);
  assign bias_addr = n;
  assign out_addr  = n;

  assign prod = in_data * w_data;

  neuron_post #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_post (
    .acc (acc),
    .prod(prod),
    .bias(bias_data),
    .q   (post_q)
  );

  // Sequencer: counters, accumulator and all registered outputs.
  // Memory reads land one cycle after issue, so accumulation lags issue by
  // one cycle and the final product is folded in during DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      i        <= '0;
      n        <= '0;
      acc      <= '0;
      rd_vld   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_we   <= 1'b0;
      out_data <= '0;
    end else begin
      rd_vld <= (state == S_RUN);
      out_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            i     <= '0;
            n     <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (rd_vld) acc <= acc + ACC_W'(prod);
          if (i == IW'(NUM_INPUTS - 1)) state <= S_DRAIN;
          else                          i     <= i + 1'b1;
        end
        S_DRAIN: begin
          out_data <= post_q;
          out_we   <= 1'b1;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (n == NW'(NUM_NEURONS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            n     <= n + 1'b1;
            i     <= '0;
            acc   <= '0;
            state <= S_RUN;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Scoreboard bench for neuron_layer_sched (NUM_INPUTS=4, NUM_NEURONS=2).
module tb_neuron_layer_sched;

  localparam int NI = 4;
  localparam int NN = 2;
  localparam int PER = NI + 2;

  logic clk, rst, start;
  logic busy, done, out_we;
  logic [1:0] in_addr;
  logic [2:0] w_addr;
  logic [0:0] bias_addr, out_addr;
  logic signed [15:0] in_data, w_data, bias_data, out_data;

  logic signed [15:0] in_mem [NI];
  logic signed [15:0] w_mem  [NN*NI];
  logic signed [15:0] b_mem  [NN];

  typedef struct {int addr; int data;} exp_t;
  exp_t exp_q[$];

  int tests = 0, fails = 0;
  int wr_cnt = 0, done_cnt = 0;

  neuron_layer_sched #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_W(16), .ACC_W(32), .FRAC_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .w_addr(w_addr), .bias_addr(bias_addr),
    .in_data(in_data), .w_data(w_data), .bias_data(bias_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories with one-cycle synchronous read latency.
  always @(posedge clk) begin
    in_data   <= in_mem[in_addr];
    w_data    <= w_mem[w_addr];
    bias_data <= b_mem[bias_addr];
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: dot product + bias in exact arithmetic, wrapped to 32 bits,
  // floor-divided by 256, clamped to 16-bit signed range.
  function automatic int model_out(input int nn);
    longint s;
    int sum32, q;
    s = 0;
    for (int j = 0; j < NI; j++) s += longint'(in_mem[j]) * longint'(w_mem[nn*NI+j]);
    s += longint'(b_mem[nn]);
    sum32 = int'(s[31:0]);
    q = sum32 >>> 8;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`ifdef NEURON_SCHED_RELU_EN
    if (q < 0) q = 0;
`endif
    return q;
  endfunction

  // Monitor: every write strobe pops and checks one expected result.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (out_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", longint'(out_addr), e.addr);
        check("wr_data", longint'(out_data), e.data);
      end
    end
  end

  task automatic push_expect();
    for (int nn = 0; nn < NN; nn++) exp_q.push_back('{nn, model_out(nn)});
  endtask

  // One full pass with cycle-exact checks; poke pulses start in RUN and DONE.
  task automatic run_pass(input bit poke);
    int ev, w0, d0, p, nn;
    ev = NN * PER;
    w0 = wr_cnt;
    d0 = done_cnt;
    push_expect();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k <= ev; k++) begin
      @(negedge clk);
      p  = k % PER;
      nn = k / PER;
      if (k < ev) begin
        check("busy", busy, 1);
        check("done_early", done, 0);
        check("we_slot", out_we, (p == NI + 1) ? 1 : 0);
        if (p < NI) begin
          check("in_addr", in_addr, p);
          check("w_addr", w_addr, nn*NI + p);
          check("bias_addr", bias_addr, nn);
        end
      end else begin
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("we_at_done", out_we, 0);
      end
      start = (poke && (k == 2 || k == ev)) ? 1'b1 : 1'b0;
    end
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("busy_after", busy, 0);
      check("we_after", out_we, 0);
    end
    check("writes_per_pass", wr_cnt - w0, NN);
    check("dones_per_pass", done_cnt - d0, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic load_const(input int iv, input int wv, input int bv);
    for (int j = 0; j < NI; j++) in_mem[j] = 16'(iv);
    for (int j = 0; j < NN*NI; j++) w_mem[j] = 16'(wv);
    for (int j = 0; j < NN; j++) b_mem[j] = 16'(bv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    int w0;
    rst = 1'b1;
    start = 1'b0;
    load_const(0, 0, 0);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", out_we, 0);
    check("rst_data", out_data, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unit weights
    load_const(256, 256, 0);
    run_pass(1'b0);

    // Negative bias
    load_const(0, 0, -300);
    run_pass(1'b0);

    // Saturation
    load_const(0, 32767, 0);
    in_mem[0] = 16'sd32767;
    in_mem[1] = 16'sd32767;
    run_pass(1'b0);

    // Start pulses while busy and during DONE
    load_const(256, 256, 0);
    run_pass(1'b1);

    // Reset during neuron 1 RUN
    w0 = wr_cnt;
    push_expect();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k <= PER + 1; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_we", out_we, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_in_addr", in_addr, 0);
    check("mid_rst_w_addr", w_addr, 0);
    check("mid_rst_bias_addr", bias_addr, 0);
    check("mid_rst_out_addr", out_addr, 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < NN*PER + 2; k++) begin
      @(negedge clk);
      check("post_rst_idle", busy, 0);
    end
    check("aborted_writes", wr_cnt - w0, 1);
    check("aborted_pending", exp_q.size(), 1);
    exp_q.delete();
    run_pass(1'b0);

    // Randomized passes
    for (int t = 0; t < 9; t++) begin
      for (int j = 0; j < NI; j++)
        in_mem[j] = (t % 3 == 0) ? 16'($urandom) : 16'($urandom_range(4000) - 2000);
      for (int j = 0; j < NN*NI; j++)
        w_mem[j] = (t % 3 == 0) ? 16'($urandom) : 16'($urandom_range(4000) - 2000);
      for (int j = 0; j < NN; j++)
        b_mem[j] = (t % 3 == 2) ? 16'($urandom) : 16'($urandom_range(1000) - 500);
      run_pass(t[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
